mem_stall_ctrl: RTL and testbench

//  MEM-stage data-memory access controller: the producer of stall_i for PC, IF_ID, ID_EX, EX_MEM and MEM_WB.

---
 rtl/mem_stall_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mem_stall_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stall_ctrl.sv
// ============================================================================
//  Module   : mem_stall_ctrl
//  Purpose  : MEM-stage data-memory controller; turns MemRead/MemWrite into a
//             req/ack transaction with a slow memory and freezes the pipeline
//             via stall_o until it completes. Optional one-entry last-load
//             buffer enabled by `define LAST_LOAD_HIT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stall_ctrl #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int ACK_TIMEOUT = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              MemRead_i,
   input  logic              MemWrite_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              stall_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              err_o
);

   localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   logic acc;
   logic hit;
   logic timeout;

   assign acc     = MemRead_i | MemWrite_i;
   assign timeout = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

`ifdef LAST_LOAD_HIT_EN
   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] tag_q, tag_d;

   // A store counts as a store even with MemRead high, so only pure loads hit.
   assign hit = valid_q & MemRead_i & ~MemWrite_i & (addr_i == tag_q);

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      if (state_q == IDLE && MemWrite_i && addr_i == tag_q) begin
         valid_d = 1'b0;
      end
      if (state_q == REQ && !we_q) begin
         if (mem_ack_i) begin
            valid_d = 1'b1;
            tag_d   = addr_q;
         end else if (timeout) begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
      end
   end
`else
   assign hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (acc && !hit) begin
               state_d = REQ;
               req_d   = 1'b1;
               we_d    = MemWrite_i;
               addr_d  = addr_i;
               wdata_d = wdata_i;
               cnt_d   = '0;
            end
         end
         REQ: begin
            if (mem_ack_i) begin
               state_d = DONE;
               req_d   = 1'b0;
               if (!we_q) rdata_d = mem_rdata_i;
            end else if (timeout) begin
               state_d = DONE;
               req_d   = 1'b0;
               err_d   = 1'b1;
               if (!we_q) rdata_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Gated by reset so a pending access cannot freeze the pipeline during reset.
   assign stall_o     = rst_i & (((state_q == IDLE) & acc & ~hit) | (state_q == REQ));
   assign mem_req_o   = req_q;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign rdata_o     = rdata_q;
   assign err_o       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stall_ctrl.sv
// ============================================================================
//  Module   : tb_mem_stall_ctrl
//  Purpose  : Self-checking bench for mem_stall_ctrl (directed table, corner
//             sequences, randomized transactions vs. a transaction-level model).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stall_ctrl;

   localparam int T = 64;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        MemRead_i = 1'b0, MemWrite_i = 1'b0;
   logic [31:0] addr_i = '0, wdata_i = '0;
   logic [31:0] rdata_o;
   logic        stall_o, mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_ack_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic        err_o;

   int checks = 0;
   int errors = 0;

   // transaction-level reference state
   logic [31:0] m_rdata = '0;
   logic        m_err   = 1'b0;
   logic        m_valid = 1'b0;
   logic [31:0] m_tag   = '0;

   mem_stall_ctrl #(.ADDR_W(32), .DATA_W(32), .ACK_TIMEOUT(T)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
      .addr_i(addr_i), .wdata_i(wdata_i),
      .rdata_o(rdata_o), .stall_o(stall_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
      .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0b required=%0b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // op: 0 = load, 1 = store, 2 = both asserted (behaves as store)
   function automatic logic model_hit(input int op, input logic [31:0] a);
      logic h;
      h = 1'b0;
`ifdef LAST_LOAD_HIT_EN
      h = (op == 0) && m_valid && (m_tag == a);
`endif
      return h;
   endfunction

   function automatic int exp_stalls(input int op, input logic [31:0] a, input int k);
      if (model_hit(op, a)) return 0;
      return (k <= T) ? k + 1 : T + 1;
   endfunction

   // Entered and left at posedge+1 of an IDLE cycle; k > T means never acked.
   task automatic do_txn(input int op, input logic [31:0] a, input logic [31:0] wd,
                         input int k, input logic [31:0] rdv, output int stalls);
      logic rd, wr, ack;
      rd = (op != 1);
      wr = (op != 0);
      stalls = 0;
      MemRead_i = rd; MemWrite_i = wr; addr_i = a; wdata_i = wd; mem_ack_i = 1'b0;
      #2;
      if (stall_o) stalls++;
      chk1("idle_noreq", mem_req_o, 1'b0);
      if (model_hit(op, a)) begin
         @(posedge clk_i); #1;
         MemRead_i = 1'b0; MemWrite_i = 1'b0;
         #2;
         chk1("hit_noreq", mem_req_o, 1'b0);
         chk32("hit_rdata", rdata_o, m_rdata);
         @(posedge clk_i); #1;
         return;
      end
      for (int j = 1; j <= T; j++) begin
         @(posedge clk_i); #1;
         ack = (j == k);
         mem_ack_i = ack;
         mem_rdata_i = ack ? rdv : $urandom;
         #2;
         if (stall_o) stalls++;
         chk1("req_high", mem_req_o, 1'b1);
         chk1("req_we", mem_we_o, wr);
         chk32("req_addr", mem_addr_o, a);
         chk32("req_wdata", mem_wdata_o, wd);
         if (ack) break;
      end
      @(posedge clk_i); #1;
      mem_ack_i = 1'(($urandom & 1));
      mem_rdata_i = $urandom;
      if (!wr) begin
         if (k <= T) begin m_rdata = rdv; m_valid = 1'b1; m_tag = a; end
         else begin m_rdata = '0; m_valid = 1'b0; end
      end else if (m_tag == a) begin
         m_valid = 1'b0;
      end
      if (k > T) m_err = 1'b1;
      #2;
      if (stall_o) stalls++;
      chk1("done_stall", stall_o, 1'b0);
      chk1("done_req", mem_req_o, 1'b0);
      chk32("done_rdata", rdata_o, m_rdata);
      chk1("done_err", err_o, m_err);
      @(posedge clk_i); #1;
      MemRead_i = 1'b0; MemWrite_i = 1'b0; mem_ack_i = 1'b0;
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         mem_ack_i = 1'(($urandom & 1));
         mem_rdata_i = $urandom;
         #2;
         chk1("gap_stall", stall_o, 1'b0);
         chk1("gap_req", mem_req_o, 1'b0);
         @(posedge clk_i); #1;
         mem_ack_i = 1'b0;
      end
      #2;
      chk32("gap_rdata", rdata_o, m_rdata);
      @(posedge clk_i); #1;
   endtask

   typedef struct {
      int          op;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          k;
      logic [31:0] rdv;
      int          stalls;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int st, op, k, r, es;
      logic [31:0] a;

      vecs[0] = '{0, 32'h40, 32'h0,        3,   32'hDEADBEEF, 4,  32'hDEADBEEF, 1'b0};
      vecs[1] = '{1, 32'h44, 32'h12345678, 1,   32'h0BAD0BAD, 2,  32'hDEADBEEF, 1'b0};
      vecs[2] = '{2, 32'h4C, 32'h0000A5A5, 2,   32'h00001111, 3,  32'hDEADBEEF, 1'b0};
      vecs[3] = '{0, 32'h80, 32'h0,        100, 32'h0,        65, 32'h0,        1'b1};
      vecs[4] = '{0, 32'h48, 32'h0,        64,  32'h000055AA, 65, 32'h000055AA, 1'b1};
      vecs[5] = '{0, 32'h50, 32'h0,        63,  32'h00000077, 64, 32'h00000077, 1'b1};

      // power-on reset
      #3;
      chk1("rst_stall", stall_o, 1'b0);
      chk1("rst_req", mem_req_o, 1'b0);
      chk32("rst_rdata", rdata_o, 32'h0);
      chk1("rst_err", err_o, 1'b0);
      @(posedge clk_i); #1;
      rst_i = 1'b1;

      for (int i = 0; i < 6; i++) begin
         do_txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].k, vecs[i].rdv, st);
         chk32("vec_stalls", st, vecs[i].stalls);
         chk32("vec_rdata", rdata_o, vecs[i].rdata);
         chk1("vec_err", err_o, vecs[i].err);
      end

      // asynchronous reset in REQ cycle 2 abandons the load
      MemRead_i = 1'b1; addr_i = 32'h40;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      chk1("pre_rst_req", mem_req_o, 1'b1);
      rst_i = 1'b0;
      #1;
      chk1("arst_req", mem_req_o, 1'b0);
      chk1("arst_stall", stall_o, 1'b0);
      chk32("arst_rdata", rdata_o, 32'h0);
      chk1("arst_err", err_o, 1'b0);
      m_rdata = '0; m_err = 1'b0; m_valid = 1'b0;
      @(posedge clk_i); #1;
      mem_ack_i = 1'b1; mem_rdata_i = 32'h99999999;
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0; MemRead_i = 1'b0; rst_i = 1'b1;
      #2;
      chk1("post_rst_req", mem_req_o, 1'b0);
      chk1("post_rst_stall", stall_o, 1'b0);
      chk32("post_rst_rdata", rdata_o, 32'h0);
      @(posedge clk_i); #1;

      // last-load buffer sequence (plain requests when the buffer is absent)
      do_txn(0, 32'h40, 32'h0, 2, 32'hCAFE0001, st);
      chk32("ll_first", st, 3);
      es = exp_stalls(0, 32'h40, 1);
      do_txn(0, 32'h40, 32'h0, 1, 32'hCAFE0001, st);
      chk32("ll_second", st, es);
      chk32("ll_second_rdata", rdata_o, 32'hCAFE0001);
      do_txn(1, 32'h60, 32'h5, 1, 32'h0, st);
      es = exp_stalls(0, 32'h40, 1);
      do_txn(0, 32'h40, 32'h0, 1, 32'hCAFE0001, st);
      chk32("ll_other_store", st, es);
      do_txn(1, 32'h40, 32'h7, 1, 32'h0, st);
      do_txn(0, 32'h40, 32'h0, 1, 32'h0000BEEF, st);
      chk32("ll_after_store", st, 2);
      chk32("ll_after_store_rdata", rdata_o, 32'h0000BEEF);

      // randomized transactions
      for (int n = 0; n < 60; n++) begin
         op = $urandom_range(0, 2);
         a  = 32'h100 + 32'($urandom_range(0, 3)) * 4;
         r  = $urandom_range(0, 9);
         k  = (r < 8) ? $urandom_range(1, 6) : ((r == 8) ? $urandom_range(62, 64) : 70);
         es = exp_stalls(op, a, k);
         do_txn(op, a, $urandom, k, $urandom, st);
         chk32("rnd_stalls", st, es);
         if ($urandom_range(0, 2) != 0) gap($urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
